// File: rtl/enc_pkg.sv
// Shared types and constants for the one-hot to index encoder block.
package enc_pkg;
    localparam int CODE_W = 4;
    localparam int IDX_W  = 2;

    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
    } entry_t;

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] PARTIAL = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;
endpackage

// File: rtl/fourtotwo_encoder_if.sv
// Input and output valid/ready channels of the encoder.
interface fourtotwo_encoder_if;
    import enc_pkg::*;

    logic [CODE_W-1:0] y;
    logic              in_valid;
    logic              in_ready;
    logic [IDX_W-1:0]  x;
    logic              err;
    logic              out_valid;
    logic              out_ready;

    modport master (output y, in_valid, out_ready, input in_ready, x, err, out_valid);
    modport slave  (input y, in_valid, out_ready, output in_ready, x, err, out_valid);
endinterface

// File: rtl/onehot_prio_enc.sv
// Combinational one-hot to index encoder; multi-hot inputs resolve by priority.
module onehot_prio_enc
    import enc_pkg::*;
#(
    parameter bit HIGH_PRIO = 1'b1
) (
    input  logic [CODE_W-1:0] y,
    output entry_t            entry
);

    always_comb begin
        entry.idx = '0;
        // Later matches overwrite earlier ones, so scan order picks the winner.
        if (HIGH_PRIO) begin
            for (int i = 0; i < CODE_W; i++)
                if (y[i]) entry.idx = IDX_W'(i);
        end else begin
            for (int i = CODE_W - 1; i >= 0; i--)
                if (y[i]) entry.idx = IDX_W'(i);
        end
        entry.err = (y == '0) || ((y & (y - CODE_W'(1))) != '0);
    end

endmodule

// File: rtl/fourtotwo_encoder.sv
// Registered 4-to-2 encoder with a small result FIFO and a saturating error counter.
module fourtotwo_encoder
    import enc_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit HIGH_PRIO = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fourtotwo_encoder_if.slave   bus,
    output logic [CNT_W-1:0]     err_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_B = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_B-1:0] DEPTH_C  = CNT_B'(DEPTH);

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head_reg, head_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_B-1:0] count_reg, count_next;
    logic [1:0]       state_reg, state_next;
    logic             out_valid_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    onehot_prio_enc #(.HIGH_PRIO(HIGH_PRIO)) u_enc (
        .y     (bus.y),
        .entry (new_entry)
    );

    assign bus.in_ready = enable && (state_reg != FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = out_valid_reg && bus.out_ready;

    always_comb begin
        rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CNT_B'(1);
        else if (!push && pop)
            count_next = count_reg - CNT_B'(1);

        if (count_next == '0)
            state_next = EMPTY;
        else if (count_next == DEPTH_C)
            state_next = FULL;
        else
            state_next = PARTIAL;

        // When the FIFO is otherwise empty after this edge, the entry being
        // written is the new head and must bypass the storage array.
        head_next = '0;
        if (count_next != '0) begin
            if (push && (count_reg == CNT_B'(pop)))
                head_next = new_entry;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr_reg] <= new_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            state_reg     <= EMPTY;
            head_reg      <= '0;
            out_valid_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            state_reg     <= state_next;
            head_reg      <= head_next;
            out_valid_reg <= (count_next != '0);
            if (push && new_entry.err && (err_count_reg != '1))
                err_count_reg <= err_count_reg + CNT_W'(1);
        end
    end

    assign bus.x         = head_reg.idx;
    assign bus.err       = head_reg.err;
    assign bus.out_valid = out_valid_reg;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_fourtotwo_encoder.sv
// Directed bench: main DUT plus low-priority and 2-bit-counter variants on shared stimulus.
module tb_fourtotwo_encoder;
    import enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] err_count;
    logic [7:0] err_count_lo;
    logic [1:0] err_count_sat;
    int         vectors = 0;
    int         miscompares = 0;

    fourtotwo_encoder_if bus ();
    fourtotwo_encoder_if bus_lo ();
    fourtotwo_encoder_if bus_sat ();

    assign bus_lo.y          = bus.y;
    assign bus_lo.in_valid   = bus.in_valid;
    assign bus_lo.out_ready  = bus.out_ready;
    assign bus_sat.y         = bus.y;
    assign bus_sat.in_valid  = bus.in_valid;
    assign bus_sat.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    fourtotwo_encoder #(.DEPTH(2), .HIGH_PRIO(1'b1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus), .err_count(err_count));
    fourtotwo_encoder #(.DEPTH(2), .HIGH_PRIO(1'b0), .CNT_W(8)) dut_lo (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus_lo), .err_count(err_count_lo));
    fourtotwo_encoder #(.DEPTH(2), .HIGH_PRIO(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus_sat), .err_count(err_count_sat));

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready)
            $display("[%0t] push y=%b", $time, bus.y);
        if (!rst && bus.out_valid && bus.out_ready)
            $display("[%0t] pop  x=%b err=%b", $time, bus.x, bus.err);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] walk_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] walk_x [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] ill_y  [5] = '{4'b0000, 4'b0110, 4'b1111, 4'b0011, 4'b1010};
    logic [1:0] ill_hi [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b11};
    logic [1:0] ill_lo [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    logic [1:0] ill_sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst = 1'b1; enable = 1'b0;
        bus.y = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_x", bus.x, 2'b00);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_in_ready_disabled", bus.in_ready, 1'b0);
        rst = 1'b0; enable = 1'b1; #1;
        chk("in_ready_enabled", bus.in_ready, 1'b1);

        // Walk the one-hot codes, each visible one cycle after its push.
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.y = walk_y[i];
            tick();
            chk("walk_valid", bus.out_valid, 1'b1);
            chk("walk_x", bus.x, walk_x[i]);
            chk("walk_err", bus.err, 1'b0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("walk_drained", bus.out_valid, 1'b0);
        chk("walk_drained_x", bus.x, 2'b00);
        chk("walk_err_count", err_count, 8'd0);

        // Illegal codes on both priority variants and the 2-bit counter.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.y = ill_y[i];
            tick();
            chk("ill_valid", bus.out_valid, 1'b1);
            chk("ill_x_hi", bus.x, ill_hi[i]);
            chk("ill_err", bus.err, 1'b1);
            chk("ill_x_lo", bus_lo.x, ill_lo[i]);
            chk("ill_count", err_count, 8'(i + 1));
            chk("ill_count_sat", err_count_sat, ill_sat[i]);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("ill_drained", bus.out_valid, 1'b0);

        // Backpressure with DEPTH=2.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.y = 4'b0001;
        tick();
        chk("bp_in_ready_1", bus.in_ready, 1'b1);
        bus.y = 4'b0010;
        tick();
        chk("bp_full_in_ready", bus.in_ready, 1'b0);
        chk("bp_head", bus.x, 2'b00);
        bus.y = 4'b0100;
        tick();
        chk("bp_held_in_ready", bus.in_ready, 1'b0);
        chk("bp_held_head", bus.x, 2'b00);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_pop_head", bus.x, 2'b01);
        chk("bp_pop_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b0;
        tick();
        chk("bp_refill_in_ready", bus.in_ready, 1'b0);
        chk("bp_refill_head", bus.x, 2'b01);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        chk("bp_drain_1", bus.x, 2'b10);
        chk("bp_drain_1_valid", bus.out_valid, 1'b1);
        tick();
        chk("bp_drain_empty", bus.out_valid, 1'b0);

        // Simultaneous push and pop with one entry held.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.y = 4'b0001;
        tick();
        chk("pp_one_held", bus.x, 2'b00);
        bus.y = 4'b1000; bus.out_ready = 1'b1;
        tick();
        chk("pp_head", bus.x, 2'b11);
        chk("pp_valid", bus.out_valid, 1'b1);
        chk("pp_count_one", bus.in_ready, 1'b1);

        // Enable low blocks input while the head still drains.
        enable = 1'b0; bus.y = 4'b0100; #1;
        chk("en_in_ready", bus.in_ready, 1'b0);
        tick();
        chk("en_drained", bus.out_valid, 1'b0);
        chk("en_no_push_x", bus.x, 2'b00);
        enable = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.y = 4'b1000;
        tick();
        chk("refill_full", bus.in_ready, 1'b0);
        chk("refill_head", bus.x, 2'b10);

        // Reset mid-operation wins over push and pop.
        rst = 1'b1; bus.out_ready = 1'b1;
        tick();
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_x", bus.x, 2'b00);
        chk("mid_rst_err", bus.err, 1'b0);
        chk("mid_rst_count", err_count, 8'd0);
        chk("mid_rst_count_sat", err_count_sat, 2'd0);
        rst = 1'b0; bus.y = 4'b0100;
        tick();
        chk("post_rst_push", bus.x, 2'b10);
        bus.in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
